// File: rtl/slot_gate_arbiter.sv
// Slot occupancy owner: arbitrates entry/exit gates, serialises table read-modify-writes.
// Result 2 edges after grant; served req must drop before the next grant, losers stay pending.
module slot_gate_arbiter #(
  parameter int N  = 16,
  parameter int FW = $clog2(N) + 1,
  parameter int CW = $clog2(N + 2)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          entry_req,
  input  logic          entry_pwd_ok,
  input  logic [FW-1:0] entry_flat,
  input  logic          exit_req,
  input  logic [FW-1:0] exit_flat,
  output logic          entry_done,
  output logic          entry_ok,
  output logic          exit_done,
  output logic          exit_ok,
  output logic [CW-1:0] occ_count,
  output logic [N:0]    occ_vec,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, LOOKUP, COMMIT, DROP} state_t;

  state_t        state, state_nxt;
  logic          side_entry;
  logic [FW-1:0] flat_r;
  logic          pwd_r;
  logic          last_grant_entry;
  logic          cur_bit;
  logic          valid_r;
  logic          any_req;
  logic          grant_entry;
  logic          served_req;
  logic          commit_ok;
  logic          grant_en;
  logic          lookup_en;
  logic          commit_en;
  logic [N:0]    flat_hot;

  assign any_req     = entry_req | exit_req;
  // On a tie the side opposite the previous tie winner goes first.
  assign grant_entry = (entry_req & exit_req) ? ~last_grant_entry : entry_req;
  assign served_req  = side_entry ? entry_req : exit_req;
  assign commit_ok   = side_entry ? (pwd_r & ~cur_bit & valid_r) : (cur_bit & valid_r);

  // One-hot of the latched flat; all-zero when the flat is out of range.
  always_comb begin
    flat_hot = '0;
    for (int k = 0; k <= N; k++) begin
      flat_hot[k] = (flat_r == FW'(k));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = LOOKUP;
      LOOKUP:  state_nxt = COMMIT;
      COMMIT:  state_nxt = DROP;
      DROP:    if (!served_req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    grant_en  = (state == IDLE) & any_req;
    lookup_en = (state == LOOKUP);
    commit_en = (state == COMMIT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      side_entry       <= 1'b0;
      flat_r           <= '0;
      pwd_r            <= 1'b0;
      last_grant_entry <= 1'b0;
      cur_bit          <= 1'b0;
      valid_r          <= 1'b0;
      occ_vec          <= '0;
      occ_count        <= '0;
      entry_done       <= 1'b0;
      entry_ok         <= 1'b0;
      exit_done        <= 1'b0;
      exit_ok          <= 1'b0;
    end else begin
      entry_done <= 1'b0;
      exit_done  <= 1'b0;
      if (grant_en) begin
        side_entry <= grant_entry;
        flat_r     <= grant_entry ? entry_flat : exit_flat;
        pwd_r      <= entry_pwd_ok;
        if (entry_req & exit_req) last_grant_entry <= grant_entry;
      end
      if (lookup_en) begin
        valid_r <= (flat_r <= FW'(N));
        // Invalid flats look occupied to entry and empty to exit, so both deny.
        cur_bit <= (flat_r <= FW'(N)) ? |(occ_vec & flat_hot) : side_entry;
      end
      if (commit_en) begin
        if (side_entry) begin
          entry_done <= 1'b1;
          entry_ok   <= commit_ok;
          if (commit_ok) begin
            occ_vec   <= occ_vec | flat_hot;
            occ_count <= occ_count + CW'(1);
          end
        end else begin
          exit_done <= 1'b1;
          exit_ok   <= commit_ok;
          if (commit_ok) begin
            occ_vec   <= occ_vec & ~flat_hot;
            occ_count <= occ_count - CW'(1);
          end
        end
      end
    end
  end

  a_count_matches_table: assert property (@(posedge clk) occ_count == CW'($countones(occ_vec)));

endmodule

// File: tb/tb_slot_gate_arbiter.sv
// Randomised bench for slot_gate_arbiter against a flat-array occupancy model.
module tb_slot_gate_arbiter;
  localparam int N  = 16;
  localparam int FW = $clog2(N) + 1;
  localparam int CW = $clog2(N + 2);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          entry_req = 1'b0;
  logic          entry_pwd_ok = 1'b0;
  logic [FW-1:0] entry_flat = '0;
  logic          exit_req = 1'b0;
  logic [FW-1:0] exit_flat = '0;
  logic          entry_done, entry_ok, exit_done, exit_ok, busy;
  logic [CW-1:0] occ_count;
  logic [N:0]    occ_vec;

  slot_gate_arbiter #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .entry_req(entry_req), .entry_pwd_ok(entry_pwd_ok), .entry_flat(entry_flat),
    .exit_req(exit_req), .exit_flat(exit_flat),
    .entry_done(entry_done), .entry_ok(entry_ok),
    .exit_done(exit_done), .exit_ok(exit_ok),
    .occ_count(occ_count), .occ_vec(occ_vec), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: one flag per flat, tie winner history, last reported results.
  bit m_occ[0:N];
  bit m_last_tie_entry;
  bit m_entry_ok;
  bit m_exit_ok;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit model_op(input bit is_entry, input int flat, input bit pwd);
    if (flat > N) return 1'b0;
    if (is_entry) begin
      if (pwd && !m_occ[flat]) begin
        m_occ[flat] = 1'b1;
        return 1'b1;
      end
      return 1'b0;
    end
    if (m_occ[flat]) begin
      m_occ[flat] = 1'b0;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic check_table(input string tag);
    int exp_vec = 0;
    int exp_cnt = 0;
    for (int k = 0; k <= N; k++) begin
      if (m_occ[k]) begin
        exp_vec += (1 << k);
        exp_cnt++;
      end
    end
    check_eq({tag, "_vec"}, int'(occ_vec), exp_vec);
    check_eq({tag, "_count"}, int'(occ_count), exp_cnt);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    entry_req = 1'b0;
    exit_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k <= N; k++) m_occ[k] = 1'b0;
    m_last_tie_entry = 1'b0;
    m_entry_ok = 1'b0;
    m_exit_ok = 1'b0;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", int'(entry_done | exit_done), 0);
    check_eq("rst_oks", int'(entry_ok | exit_ok), 0);
    check_table("rst");
    rst_n = 1'b1;
  endtask

  task automatic wait_any_done(output int cyc, output bit got_entry, output bit got_exit);
    cyc = 0;
    got_entry = 1'b0;
    got_exit = 1'b0;
    while (cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
      if (entry_done || exit_done) begin
        got_entry = entry_done;
        got_exit  = exit_done;
        break;
      end
    end
    if (!(got_entry || got_exit)) check_eq("done_timeout", 0, 1);
  endtask

  task automatic check_result(input string tag, input bit is_entry, input bit exp);
    if (is_entry) m_entry_ok = exp;
    else          m_exit_ok  = exp;
    check_eq({tag, "_entry_ok"}, entry_ok, m_entry_ok);
    check_eq({tag, "_exit_ok"}, exit_ok, m_exit_ok);
    check_eq({tag, "_busy"}, busy, 1);
  endtask

  task automatic serve_one(input bit is_entry, input int flat, input bit pwd);
    bit exp, ge, gx;
    int cyc;
    exp = model_op(is_entry, flat, pwd);
    if (is_entry) begin
      entry_req = 1'b1; entry_flat = FW'(flat); entry_pwd_ok = pwd;
    end else begin
      exit_req = 1'b1; exit_flat = FW'(flat);
    end
    wait_any_done(cyc, ge, gx);
    check_eq("one_latency", cyc, 3);
    check_eq("one_side", ge, is_entry);
    check_eq("one_other_done", is_entry ? gx : ge, 0);
    check_result("one", is_entry, exp);
    check_table("one");
    entry_req = 1'b0;
    exit_req = 1'b0;
    @(posedge clk);
    #1;
    check_eq("one_pulse", int'(entry_done | exit_done), 0);
    check_eq("one_idle", busy, 0);
  endtask

  task automatic serve_tie(input int ef, input bit pwd, input int xf);
    bit first_entry, exp1, exp2, ge, gx;
    int cyc;
    first_entry = !m_last_tie_entry;
    m_last_tie_entry = first_entry;
    exp1 = first_entry ? model_op(1'b1, ef, pwd) : model_op(1'b0, xf, 1'b0);
    exp2 = first_entry ? model_op(1'b0, xf, 1'b0) : model_op(1'b1, ef, pwd);
    entry_req = 1'b1; entry_flat = FW'(ef); entry_pwd_ok = pwd;
    exit_req = 1'b1; exit_flat = FW'(xf);
    wait_any_done(cyc, ge, gx);
    check_eq("tie1_latency", cyc, 3);
    check_eq("tie1_side", ge, first_entry);
    check_result("tie1", first_entry, exp1);
    if (first_entry) entry_req = 1'b0;
    else             exit_req = 1'b0;
    wait_any_done(cyc, ge, gx);
    check_eq("tie2_latency", cyc, 4);
    check_eq("tie2_side", ge, !first_entry);
    check_result("tie2", !first_entry, exp2);
    check_table("tie");
    entry_req = 1'b0;
    exit_req = 1'b0;
    @(posedge clk);
    #1;
    check_eq("tie_idle", busy, 0);
  endtask

  initial begin
    do_reset();

    serve_one(1'b1, 3, 1'b1);
    serve_one(1'b1, 3, 1'b1);
    serve_one(1'b1, 5, 1'b0);
    serve_one(1'b0, 3, 1'b0);
    serve_one(1'b0, 3, 1'b0);

    do_reset();
    serve_one(1'b1, 2, 1'b1);
    serve_tie(7, 1'b1, 2);
    serve_tie(8, 1'b1, 7);
    check_eq("tie_final_count", int'(occ_count), 1);

    serve_one(1'b1, N + 1, 1'b1);
    serve_one(1'b0, N + 1, 1'b0);

    do_reset();
    serve_one(1'b1, 11, 1'b1);
    entry_req = 1'b1; entry_flat = FW'(4); entry_pwd_ok = 1'b1;
    @(posedge clk); #1;
    check_eq("abort_lookup_busy", busy, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_eq("abort_no_done", entry_done, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_vec", int'(occ_vec), 0);
    check_eq("abort_count", int'(occ_count), 0);
    entry_req = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k <= N; k++) m_occ[k] = 1'b0;
    m_last_tie_entry = 1'b0;
    m_entry_ok = 1'b0;
    m_exit_ok = 1'b0;
    @(posedge clk); #1;
    check_eq("abort_after_done", entry_done, 0);

    for (int k = 0; k <= N; k++) serve_one(1'b1, k, 1'b1);
    check_eq("full_count", int'(occ_count), N + 1);
    serve_one(1'b1, 9, 1'b1);
    check_eq("full_no_wrap", int'(occ_count), N + 1);

    for (int i = 0; i < 200; i++) begin
      int op, f1, f2;
      bit pwd;
      op  = $urandom_range(0, 2);
      f1  = $urandom_range(0, N + 2);
      f2  = $urandom_range(0, N + 2);
      pwd = ($urandom_range(0, 4) != 0);
      case (op)
        0:       serve_one(1'b1, f1, pwd);
        1:       serve_one(1'b0, f1, 1'b0);
        default: serve_tie(f1, pwd, f2);
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "bench timeout");
  end
endmodule
